// File: rtl/de0_nano_sopc_pio_pulse_out.sv
// Avalon-MM output PIO with set/clear access and a timed one-shot inversion pulse plus completion IRQ.
// Latency: register writes reach out_port one clk later; readdata is registered (1-cycle read latency).
// Backpressure: none; the slave never stalls, and a PULSE write while busy is dropped.
module de0_nano_sopc_pio_pulse_out #(
  parameter int                WIDTH       = 8,
  parameter int                CNT_WIDTH   = 16,
  parameter logic [WIDTH-1:0]  RESET_VALUE = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              chipselect,
  input  logic [2:0]        address,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic              irq,
  output logic [WIDTH-1:0]  out_port
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_PULSE = 1'b1
  } state_t;

  localparam logic [2:0] A_DATA  = 3'd0;
  localparam logic [2:0] A_SET   = 3'd1;
  localparam logic [2:0] A_CLR   = 3'd2;
  localparam logic [2:0] A_LEN   = 3'd3;
  localparam logic [2:0] A_PULSE = 3'd4;
  localparam logic [2:0] A_STAT  = 3'd5;
  localparam logic [2:0] A_IRQEN = 3'd6;

  state_t               r_state;
  logic [WIDTH-1:0]     r_data;
  logic [CNT_WIDTH-1:0] r_len;
  logic [WIDTH-1:0]     r_mask;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic                 r_done;
  logic                 r_irq_en;
  logic [31:0]          r_readdata;

  state_t               w_state_nxt;
  logic [WIDTH-1:0]     w_mask_nxt;
  logic [CNT_WIDTH-1:0] w_cnt_nxt;
  logic                 w_done_set;
  logic                 w_wr;
  logic                 w_busy;
  logic [31:0]          w_rd;
  logic [WIDTH-1:0]     w_wd;

  assign w_wr     = chipselect & ~write_n;
  assign w_busy   = (r_state == ST_PULSE);
  assign w_wd     = writedata[WIDTH-1:0];
  assign out_port = r_data ^ r_mask;
  assign irq      = r_done & r_irq_en;
  assign readdata = r_readdata;

  // Pulse FSM next state: start only from idle, count down, drop the mask on the last cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_mask_nxt  = r_mask;
    w_cnt_nxt   = r_cnt;
    w_done_set  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_wr && address == A_PULSE) begin
          if (r_len != '0) begin
            w_state_nxt = ST_PULSE;
            w_mask_nxt  = w_wd;
            w_cnt_nxt   = r_len;
          end else begin
            // Zero-length pulse completes immediately without touching the output.
            w_done_set = 1'b1;
          end
        end
      end
      ST_PULSE: begin
        if (r_cnt == CNT_WIDTH'(1)) begin
          w_state_nxt = ST_IDLE;
          w_mask_nxt  = '0;
          w_done_set  = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - CNT_WIDTH'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_mask_nxt  = '0;
      end
    endcase
  end

  // Pulse FSM state, mask and counter registers; reset aborts any pulse in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_mask  <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_mask  <= w_mask_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Software-visible registers; a completion on the same edge beats a W1C of done.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_data   <= RESET_VALUE;
      r_len    <= '0;
      r_done   <= 1'b0;
      r_irq_en <= 1'b0;
    end else begin
      if (w_wr) begin
        case (address)
          A_DATA:  r_data   <= w_wd;
          A_SET:   r_data   <= r_data | w_wd;
          A_CLR:   r_data   <= r_data & ~w_wd;
          A_LEN:   r_len    <= writedata[CNT_WIDTH-1:0];
          A_IRQEN: r_irq_en <= writedata[0];
          default: ;
        endcase
      end
      if (w_done_set) begin
        r_done <= 1'b1;
      end else if (w_wr && address == A_STAT && writedata[1]) begin
        r_done <= 1'b0;
      end
    end
  end

  // Read mux, zero-extended; sampled every edge independent of chipselect.
  always_comb begin
    w_rd = '0;
    case (address)
      A_DATA:  w_rd[WIDTH-1:0]     = r_data;
      A_LEN:   w_rd[CNT_WIDTH-1:0] = r_len;
      A_PULSE: w_rd[WIDTH-1:0]     = r_mask;
      A_STAT:  w_rd[1:0]           = {r_done, w_busy};
      A_IRQEN: w_rd[0]             = r_irq_en;
      default: ;
    endcase
  end

  // Registered read data.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_readdata <= '0;
    end else begin
      r_readdata <= w_rd;
    end
  end

endmodule
